// File: rtl/mem_port_arbiter.sv
// Shares the single RV32I memory port between instruction fetch and load/store.
// Data side wins contention until fetch has waited STARVE_LIMIT data grants in a row.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [2:0]  d_funct3,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic        d_misaligned,
  output logic [31:0] rdata,
  output logic        mem_write_mem,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        isData_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        misal_q;
  logic        ifRvalid_q;
  logic        dRvalid_q;
  logic        dMisal_q;
  logic [31:0] rdata_q;
  logic        ready;
  logic        dMisalNow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_gnt || d_gnt) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = (if_gnt || d_gnt) ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grants are gated by rst_n so every output reads 0 while reset is held.
  always_comb begin
    ready         = rst_n && (state_q != ACCESS);
    d_gnt         = 1'b0;
    if_gnt        = 1'b0;
    if (ready) begin
      if (d_req && !(if_req && (streak_q == LIMIT))) d_gnt  = 1'b1;
      else if (if_req)                               if_gnt = 1'b1;
    end
    busy          = (state_q == ACCESS);
    mem_write_mem = busy && we_q && !misal_q;
  end

  always_comb begin
    streak_d = streak_q;
    if (if_gnt)     streak_d = 4'd0;
    else if (d_gnt) streak_d = !if_req ? 4'd0 :
                               (streak_q == LIMIT) ? LIMIT : streak_q + 4'd1;
  end

  assign dMisalNow = (d_funct3[1] && (d_addr[1:0] != 2'b00)) ||
                     ((d_funct3[1:0] == 2'b01) && d_addr[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= 4'd0;
      isData_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      funct3_q <= 3'd0;
      we_q     <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      streak_q <= streak_d;
      if (d_gnt) begin
        isData_q <= 1'b1;
        addr_q   <= d_addr;
        wdata_q  <= d_wdata;
        funct3_q <= d_funct3;
        we_q     <= d_we;
        misal_q  <= dMisalNow;
      end else if (if_gnt) begin
        isData_q <= 1'b0;
        addr_q   <= if_addr;
        wdata_q  <= 32'd0;
        funct3_q <= 3'b010;
        we_q     <= 1'b0;
        misal_q  <= 1'b0;
      end
    end
  end

  // Responses are produced on the edge that closes ACCESS and last for the RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifRvalid_q <= 1'b0;
      dRvalid_q  <= 1'b0;
      dMisal_q   <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      ifRvalid_q <= (state_q == ACCESS) && !isData_q;
      dRvalid_q  <= (state_q == ACCESS) && isData_q;
      dMisal_q   <= (state_q == ACCESS) && isData_q && misal_q;
      if (state_q == ACCESS) rdata_q <= (we_q || misal_q) ? 32'd0 : mem_read_data;
    end
  end

  assign if_rvalid         = ifRvalid_q;
  assign d_rvalid          = dRvalid_q;
  assign d_misaligned      = dMisal_q;
  assign rdata             = rdata_q;
  assign mem_funct3        = funct3_q;
  assign mem_write_address = addr_q;
  assign mem_read_address  = addr_q;
  assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant/ordering model plus a byte-array
// reference memory predict every grant and response; a monitor checks responses.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic        d_misaligned;
  logic [31:0] rdata;
  logic        mem_write_mem;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        busy;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_misaligned(d_misaligned),
    .rdata(rdata), .mem_write_mem(mem_write_mem), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          isData;
    bit          misal;
    logic [31:0] data;
    int          due;
  } resp_t;

  resp_t       expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cycleCount = 0;
  int          lastGnt = -100;
  int          streak = 0;
  bit          accWe;
  logic [31:0] accAddr;
  logic [2:0]  accF3;
  logic [7:0]  refMem[256];
  logic [31:0] wordMem[64];

  function automatic logic [31:0] initWord(input int i);
    return (i == 4) ? 32'hDEADBEEF : 32'h9E3779B9 * 32'(i + 1);
  endfunction

  // Memory environment: word array, loads sampled on negedge, stores on posedge.
  initial begin
    for (int i = 0; i < 64; i++) wordMem[i] = initWord(i);
    forever begin
      @(posedge clk);
      if (mem_write_mem) begin
        case (mem_funct3[1:0])
          2'b00:   wordMem[mem_write_address[7:2]][int'(mem_write_address[1:0])*8 +: 8] = mem_write_data[7:0];
          2'b01:   wordMem[mem_write_address[7:2]][int'(mem_write_address[1:0])*8 +: 16] = mem_write_data[15:0];
          default: wordMem[mem_write_address[7:2]] = mem_write_data;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] sh;
    sh = wordMem[mem_read_address[7:2]] >> {mem_read_address[1:0], 3'b000};
    case (mem_funct3)
      3'b000:  mem_read_data <= {{24{sh[7]}}, sh[7:0]};
      3'b100:  mem_read_data <= {24'd0, sh[7:0]};
      3'b001:  mem_read_data <= {{16{sh[15]}}, sh[15:0]};
      3'b101:  mem_read_data <= {16'd0, sh[15:0]};
      default: mem_read_data <= wordMem[mem_read_address[7:2]];
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int accSize(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
  endfunction

  function automatic logic [31:0] refLoad(input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = accSize(f3);
    v = 32'd0;
    for (int k = 0; k < n; k++) v |= 32'(refMem[8'(a + 32'(k))]) << (8 * k);
    if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic refStore(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
    for (int k = 0; k < accSize(f3); k++) refMem[8'(a + 32'(k))] = wd[8*k +: 8];
  endtask

  // One clock of model evaluation: predicts grants and queues the expected response.
  task automatic stepCycle(output bit gotI, output bit gotD);
    bit    expBusy, eI, eD, mis;
    resp_t r;
    @(negedge clk);
    expBusy = (cycleCount == lastGnt + 1);
    eD = !expBusy && d_req && !(if_req && streak >= STARVE_LIMIT);
    eI = !expBusy && if_req && !eD;
    checkOutput("grant", {30'd0, if_gnt, d_gnt}, {30'd0, eI, eD});
    checkOutput("busy", busy, expBusy);
    if (expBusy) begin
      checkOutput("memWe", mem_write_mem, accWe);
      checkOutput("memAddr", mem_read_address, accAddr);
      checkOutput("memF3", mem_funct3, accF3);
    end
    if (eD) begin
      mis = (d_addr % accSize(d_funct3)) != 0;
      r.isData = 1'b1;
      r.misal  = mis;
      r.data   = (mis || d_we) ? 32'd0 : refLoad(d_addr, d_funct3);
      r.due    = cycleCount + 2;
      expQ.push_back(r);
      if (d_we && !mis) refStore(d_addr, d_funct3, d_wdata);
      accWe   = d_we && !mis;
      accAddr = d_addr;
      accF3   = d_funct3;
      streak  = if_req ? ((streak < STARVE_LIMIT) ? streak + 1 : streak) : 0;
      lastGnt = cycleCount;
    end
    if (eI) begin
      r.isData = 1'b0;
      r.misal  = 1'b0;
      r.data   = refLoad(if_addr, 3'b010);
      r.due    = cycleCount + 2;
      expQ.push_back(r);
      accWe   = 1'b0;
      accAddr = if_addr;
      accF3   = 3'b010;
      streak  = 0;
      lastGnt = cycleCount;
    end
    gotI = eI;
    gotD = eD;
    @(posedge clk);
    cycleCount++;
    #1;
  endtask

  task automatic newData();
    d_we     = 1'($urandom_range(1));
    case ($urandom_range(d_we ? 2 : 4))
      0:       d_funct3 = 3'b000;
      1:       d_funct3 = 3'b001;
      2:       d_funct3 = 3'b010;
      3:       d_funct3 = 3'b100;
      default: d_funct3 = 3'b101;
    endcase
    d_addr  = 32'($urandom_range(255));
    d_wdata = $urandom;
  endtask

  task automatic applyStimulus(input int n, input int ifPct, input int dPct);
    bit gi, gd;
    for (int c = 0; c < n; c++) begin
      stepCycle(gi, gd);
      if (gi || !if_req) begin
        if_req  = ($urandom_range(99) < ifPct);
        if_addr = 32'($urandom_range(63)) << 2;
      end
      if (gd || !d_req) begin
        d_req = ($urandom_range(99) < dPct);
        newData();
      end
    end
  endtask

  task automatic issueData(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bit gi, gd;
    int n;
    d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd; d_req = 1'b1;
    n = 0;
    gd = 1'b0;
    while (!gd && n < 40) begin
      stepCycle(gi, gd);
      n++;
    end
    if (!gd) checkOutput("dGrantTimeout", 32'd0, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic issueFetch(input logic [31:0] a);
    bit gi, gd;
    int n;
    if_addr = a; if_req = 1'b1;
    n = 0;
    gi = 1'b0;
    while (!gi && n < 40) begin
      stepCycle(gi, gd);
      n++;
    end
    if (!gi) checkOutput("ifGrantTimeout", 32'd0, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    bit gi, gd;
    for (int c = 0; c < n; c++) stepCycle(gi, gd);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, {22'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, d_misaligned,
                               busy, mem_write_mem, mem_funct3},
                32'd0);
    checkOutput({tag, "Data"}, rdata | mem_read_address | mem_write_address | mem_write_data, 32'd0);
  endtask

  // Response monitor: pops the oldest expectation whenever a response pulse shows up.
  always @(negedge clk) begin
    resp_t e;
    if (expQ.size() > 0 && expQ[0].due < cycleCount) begin
      checks++;
      errors++;
      $display("[TB] FAIL missingResp due=%0d now=%0d", expQ[0].due, cycleCount);
      void'(expQ.pop_front());
    end
    if (if_rvalid || d_rvalid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedResp if_rvalid=%b d_rvalid=%b expected none", if_rvalid, d_rvalid);
      end else begin
        e = expQ.pop_front();
        checkOutput("rvSource", {30'd0, if_rvalid, d_rvalid}, e.isData ? 32'd1 : 32'd2);
        checkOutput("rvCycle", cycleCount, e.due);
        checkOutput("rvData", rdata, e.data);
        checkOutput("rvMisal", d_misaligned, e.misal);
      end
    end else if (d_misaligned) begin
      checks++;
      errors++;
      $display("[TB] FAIL misalNoValid actual=1 expected=0");
    end
  end

  initial begin
    logic [31:0] saved;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) refMem[i*4+k] = initWord(i) >> (8 * k);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] fetch of 0x10");
    issueFetch(32'h10);
    idleCycles(3);

    $display("[TB] store then load back to back");
    issueData(1'b1, 3'b010, 32'h20, 32'h12345678);
    issueData(1'b0, 3'b100, 32'h21, 32'h0);
    idleCycles(3);

    $display("[TB] misaligned store and load");
    issueData(1'b1, 3'b010, 32'h22, 32'hA5A5A5A5);
    issueData(1'b0, 3'b001, 32'h23, 32'h0);
    idleCycles(3);

    $display("[TB] sustained contention");
    if_req = 1'b1; if_addr = 32'h30;
    d_req = 1'b1; newData();
    applyStimulus(40, 100, 100);
    if_req = 1'b0; d_req = 1'b0;
    idleCycles(3);

    $display("[TB] random traffic");
    applyStimulus(800, 50, 60);
    if_req = 1'b0; d_req = 1'b0;
    idleCycles(4);

    $display("[TB] reset during a store access");
    saved = refLoad(32'h40, 3'b010);
    issueData(1'b1, 3'b010, 32'h40, 32'hCAFEF00D);
    #2;
    checkOutput("rstPreWe", mem_write_mem, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstWeDrop", mem_write_mem, 1'b0);
    void'(expQ.pop_back());
    refStore(32'h40, 3'b010, saved);
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("midReset");
    checkOutput("rstWord", wordMem[16], saved);
    rst_n = 1'b1;
    lastGnt = -100;
    streak  = 0;
    idleCycles(2);
    checkAllZero("postReset");
    issueFetch(32'h40);
    idleCycles(4);

    for (int i = 0; i < 64; i++) checkOutput("memImage", wordMem[i], refLoad(32'(i * 4), 3'b010));
    checkOutput("queueDrained", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single read/write port of the RV32I memory block between the instruction-fetch unit and the load/store unit.
- Uses valid/grant request handshakes and one-cycle response pulses.
- Drives the memory's write_mem, funct3, write_address, write_data and read_address, and captures read_data.
- Runs one access at a time. Data side has priority, with an anti-starvation limit for fetch.

Parameters:
STARVE_LIMIT, 4, maximum consecutive data grants while if_req is pending; the next grant then goes to fetch (range 1..15)

Ports:
clk  in  1  system clock; all state on posedge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; payload held stable until if_gnt
if_addr  in  32  fetch word address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  one-cycle pulse: fetch data valid on rdata
d_req  in  1  data request; payload held stable until d_gnt
d_we  in  1  1 = store, 0 = load
d_funct3  in  3  RV32I load/store funct3
d_addr  in  32  byte address
d_wdata  in  32  store data (LSB-aligned)
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  one-cycle pulse: load data or store acknowledge
d_misaligned  out  1  qualifies d_rvalid: access was misaligned and was suppressed
rdata  out  32  response data, shared by both requesters
mem_write_mem  out  1  to memory write_mem
mem_funct3  out  3  to memory funct3
mem_write_address  out  32  to memory write_address
mem_write_data  out  32  to memory write_data
mem_read_address  out  32  to memory read_address
mem_read_data  in  32  from memory read_data
busy  out  1  high while an access occupies the memory port

Behaviour:
Reset
- Async while rst_n low: state IDLE; all outputs 0; streak counter 0; captured registers 0.
- A reset mid-access drops mem_write_mem immediately, so no partial write occurs.
- No response is issued for an access aborted by reset.

FSM states and transitions
- IDLE: ready; goes to ACCESS on any grant.
- ACCESS: exactly one cycle; always goes to RESP.
- RESP: ready; goes to ACCESS on a grant, else to IDLE.
- Throughput: one access per 2 cycles back-to-back.

Grant rules (evaluated combinationally in IDLE or RESP only)
- Only d_req: d_gnt.
- Only if_req: if_gnt.
- Both requesting: d_gnt, unless streak == STARVE_LIMIT, in which case if_gnt.
- At most one gnt per cycle.
- Never grant in ACCESS: if_gnt = d_gnt = 0 there.

Streak counter
- Increments on a d_gnt while if_req = 1.
- Clears on any if_gnt.
- Clears on a d_gnt while if_req = 0.
- Saturates at STARVE_LIMIT.

Capture on grant
- Register requester id, address, funct3, we and wdata.
- Fetch always uses funct3 = 3'b010 and we = 0.

Misalignment check (data side, at grant)
- Misaligned if funct3[1] = 1 and addr[1:0] != 0.
- Misaligned if funct3[1:0] = 2'b01 and addr[0] = 1.
- A misaligned access still takes ACCESS/RESP, but mem_write_mem stays 0.
- Fetch is never checked.

Memory port drive during ACCESS (from captured registers)
- mem_read_address = addr; the memory samples it on the negedge inside ACCESS.
- mem_funct3 = funct3.
- mem_write_address = addr.
- mem_write_data = wdata.
- mem_write_mem = we & ~misaligned; the write commits on the posedge ending ACCESS.
- busy = 1.

Memory port drive outside ACCESS
- mem_write_mem = 0 and busy = 0.
- Address, funct3 and data outputs hold their last values.

Response (on the posedge ending ACCESS, valid throughout RESP)
- rdata = mem_read_data for loads and fetches; 0 for stores and misaligned accesses.
- Exactly one of if_rvalid / d_rvalid pulses for one cycle.
- d_misaligned is valid with d_rvalid and 0 otherwise.
- rdata holds its value until the next response.

Latency and handshake
- Grant in cycle N gives rvalid in cycle N+2.
- A new grant is allowed in the same cycle as rvalid (the RESP cycle).
- A requester may deassert req after gnt.
- Behaviour is undefined if payload changes before gnt.

Test Plan:
- Fetch only: if_addr=0x10, mem word[4]=0xDEADBEEF -> if_gnt cycle 0, busy cycle 1, if_rvalid cycle 2 with rdata=0xDEADBEEF, mem_funct3=3'b010.
- Store then load: sw 0x12345678 @0x20, then lbu @0x21 back-to-back -> d_rvalid (rdata=0) at cycle 2, load granted in cycle 2, d_rvalid cycle 4 rdata=0x00000056.
- Contention: if_req and d_req held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; no double gnt; gnt only in IDLE/RESP.
- Misaligned: sw @0x22 and lh @0x23 -> mem_write_mem never high, memory unchanged, each d_rvalid with d_misaligned=1 and rdata=0.
- Reset mid-access: assert rst_n=0 during the ACCESS of a store to 0x40 -> mem_write_mem drops asynchronously, word 0x40 unchanged, no rvalid; after release all outputs 0, state IDLE.
- MMIO read: lw @0xFFFFFFF8 after 24000 clocks -> d_rvalid with rdata ≥ 1 (millis).
